// File: rtl/vga_pkg.sv
// Shared VGA timing constants, widths and the sync bundle type for the frame reader and any overlay block.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
  localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

  localparam int VGA_ADDR_W  = 19;
  localparam int COLOR_ID_W  = 8;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
    logic frame_start;
  } vga_sync_t;

  localparam vga_sync_t VGA_SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, active: 1'b0, frame_start: 1'b0};

  function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running raster counters with registered hsync/vsync/active/frame-start flags.
// Flags are computed from the next count, so they line up with hcnt/vcnt in the same cycle.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int H_FP        = VGA_H_FP,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BP        = VGA_H_BP,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int V_FP        = VGA_V_FP,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BP        = VGA_V_BP,
  parameter int H_CNT_WIDTH = 10,
  parameter int V_CNT_WIDTH = 10
)(
  input  logic                   clk,
  input  logic                   rst,
  output logic [H_CNT_WIDTH-1:0] hcnt,
  output logic [V_CNT_WIDTH-1:0] vcnt,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   active,
  output logic                   frame_start
);

  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [H_CNT_WIDTH-1:0] H_LAST       = H_CNT_WIDTH'(H_TOTAL - 1);
  localparam logic [H_CNT_WIDTH-1:0] H_VIS        = H_CNT_WIDTH'(H_ACTIVE);
  localparam logic [H_CNT_WIDTH-1:0] H_SYNC_START = H_CNT_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [H_CNT_WIDTH-1:0] H_SYNC_STOP  = H_CNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_CNT_WIDTH-1:0] V_LAST       = V_CNT_WIDTH'(V_TOTAL - 1);
  localparam logic [V_CNT_WIDTH-1:0] V_VIS        = V_CNT_WIDTH'(V_ACTIVE);
  localparam logic [V_CNT_WIDTH-1:0] V_SYNC_START = V_CNT_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [V_CNT_WIDTH-1:0] V_SYNC_STOP  = V_CNT_WIDTH'(V_ACTIVE + V_FP + V_SYNC);

  logic [H_CNT_WIDTH-1:0] hcnt_reg, hcnt_next;
  logic [V_CNT_WIDTH-1:0] vcnt_reg, vcnt_next;
  logic                   hsync_reg, vsync_reg, active_reg, frame_start_reg;
  logic                   line_last;

  assign line_last = (hcnt_reg == H_LAST);

  always_comb begin
    hcnt_next = line_last ? '0 : hcnt_reg + 1'b1;
    vcnt_next = vcnt_reg;
    if (line_last)
      vcnt_next = (vcnt_reg == V_LAST) ? '0 : vcnt_reg + 1'b1;
  end

  // Reset parks the counters on the last (blanked) position so the first edge after release lands on (0,0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt_reg        <= H_LAST;
      vcnt_reg        <= V_LAST;
      hsync_reg       <= 1'b1;
      vsync_reg       <= 1'b1;
      active_reg      <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      hcnt_reg        <= hcnt_next;
      vcnt_reg        <= vcnt_next;
      hsync_reg       <= !((hcnt_next >= H_SYNC_START) && (hcnt_next < H_SYNC_STOP));
      vsync_reg       <= !((vcnt_next >= V_SYNC_START) && (vcnt_next < V_SYNC_STOP));
      active_reg      <= (hcnt_next < H_VIS) && (vcnt_next < V_VIS);
      frame_start_reg <= (hcnt_next == '0) && (vcnt_next == '0);
    end
  end

  assign hcnt        = hcnt_reg;
  assign vcnt        = vcnt_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign active      = active_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: rtl/vga_frame_reader.sv
// VGA scan-out: raster address generation, RAM-latency alignment pipeline and registered outputs.
// Optional SUPERPIXEL_GRID_EN overlays a grid colour on every GRID_PITCH-th active row and column.
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int H_ACTIVE       = VGA_H_ACTIVE,
  parameter int H_FP           = VGA_H_FP,
  parameter int H_SYNC         = VGA_H_SYNC,
  parameter int H_BP           = VGA_H_BP,
  parameter int V_ACTIVE       = VGA_V_ACTIVE,
  parameter int V_FP           = VGA_V_FP,
  parameter int V_SYNC         = VGA_V_SYNC,
  parameter int V_BP           = VGA_V_BP,
  parameter int H_CNT_WIDTH    = 10,
  parameter int V_CNT_WIDTH    = 10,
  parameter int VGA_ADDR_WIDTH = VGA_ADDR_W,
  parameter int COLOR_ID_WIDTH = COLOR_ID_W,
  parameter int RD_LATENCY     = 2
`ifdef SUPERPIXEL_GRID_EN
  ,
  parameter int                        GRID_PITCH = 10,
  parameter logic [COLOR_ID_WIDTH-1:0] GRID_COLOR = 8'hFF
`endif
)(
  input  logic                      clk,
  input  logic                      rst,
  output logic [VGA_ADDR_WIDTH-1:0] oaddr,
  output logic                      ordreq,
  input  logic [COLOR_ID_WIDTH-1:0] idata,
  output logic [COLOR_ID_WIDTH-1:0] ocolor,
  output logic                      ohsync,
  output logic                      ovsync,
  output logic                      oblank,
  output logic                      oframe_start
);

  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [H_CNT_WIDTH-1:0]    H_LAST   = H_CNT_WIDTH'(H_TOTAL - 1);
  localparam logic [V_CNT_WIDTH-1:0]    V_LAST   = V_CNT_WIDTH'(V_TOTAL - 1);
  localparam logic [VGA_ADDR_WIDTH-1:0] ADDR_MAX = VGA_ADDR_WIDTH'(H_ACTIVE * V_ACTIVE - 1);

  logic [H_CNT_WIDTH-1:0] hcnt;
  logic [V_CNT_WIDTH-1:0] vcnt;
  logic                   t_hsync, t_vsync, t_active, t_frame_start;
  logic                   frame_last;
  vga_sync_t              raw_sync, sync_d;

  vga_timing_gen #(
    .H_ACTIVE    (H_ACTIVE),
    .H_FP        (H_FP),
    .H_SYNC      (H_SYNC),
    .H_BP        (H_BP),
    .V_ACTIVE    (V_ACTIVE),
    .V_FP        (V_FP),
    .V_SYNC      (V_SYNC),
    .V_BP        (V_BP),
    .H_CNT_WIDTH (H_CNT_WIDTH),
    .V_CNT_WIDTH (V_CNT_WIDTH)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .hcnt        (hcnt),
    .vcnt        (vcnt),
    .hsync       (t_hsync),
    .vsync       (t_vsync),
    .active      (t_active),
    .frame_start (t_frame_start)
  );

  assign frame_last = (hcnt == H_LAST) && (vcnt == V_LAST);
  assign raw_sync   = '{hsync: t_hsync, vsync: t_vsync, active: t_active, frame_start: t_frame_start};

  // Running raster address: holds at ADDR_MAX after the last visible pixel until the frame wraps.
  logic [VGA_ADDR_WIDTH-1:0] addr_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      addr_reg <= '0;
    else if (frame_last)
      addr_reg <= '0;
    else if (t_active && (addr_reg != ADDR_MAX))
      addr_reg <= addr_reg + 1'b1;
  end

  assign oaddr  = addr_reg;
  assign ordreq = t_active;

  genvar gi;
  generate
    for (gi = 0; gi < RD_LATENCY; gi++) begin : g_align
      vga_sync_t stage_reg;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) stage_reg <= VGA_SYNC_IDLE;
          else      stage_reg <= raw_sync;
        end
      end else begin : g_tail
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) stage_reg <= VGA_SYNC_IDLE;
          else      stage_reg <= g_align[gi-1].stage_reg;
        end
      end
    end
  endgenerate

  assign sync_d = g_align[RD_LATENCY-1].stage_reg;

  logic [COLOR_ID_WIDTH-1:0] pix_color;

`ifdef SUPERPIXEL_GRID_EN
  localparam int GW = (GRID_PITCH > 1) ? $clog2(GRID_PITCH) : 1;
  localparam logic [GW-1:0] G_LAST = GW'(GRID_PITCH - 1);

  // x%GRID_PITCH and y%GRID_PITCH tracked by wrapping counters that stay in step with hcnt/vcnt.
  logic [GW-1:0] gx_reg, gy_reg;
  logic          grid_now, grid_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gx_reg <= '0;
      gy_reg <= '0;
    end else if (hcnt == H_LAST) begin
      gx_reg <= '0;
      if (frame_last)          gy_reg <= '0;
      else if (gy_reg == G_LAST) gy_reg <= '0;
      else                     gy_reg <= gy_reg + 1'b1;
    end else begin
      gx_reg <= (gx_reg == G_LAST) ? '0 : gx_reg + 1'b1;
    end
  end

  assign grid_now = (gx_reg == '0) || (gy_reg == '0);

  for (gi = 0; gi < RD_LATENCY; gi++) begin : g_grid
    logic bit_reg;
    if (gi == 0) begin : g_head
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) bit_reg <= 1'b0;
        else      bit_reg <= grid_now;
      end
    end else begin : g_tail
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) bit_reg <= 1'b0;
        else      bit_reg <= g_grid[gi-1].bit_reg;
      end
    end
  end

  assign grid_d    = g_grid[RD_LATENCY-1].bit_reg;
  assign pix_color = grid_d ? GRID_COLOR : idata;
`else
  assign pix_color = idata;
`endif

  logic [COLOR_ID_WIDTH-1:0] ocolor_reg;
  logic                      ohsync_reg, ovsync_reg, oblank_reg, oframe_start_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ocolor_reg       <= '0;
      ohsync_reg       <= 1'b1;
      ovsync_reg       <= 1'b1;
      oblank_reg       <= 1'b1;
      oframe_start_reg <= 1'b0;
    end else begin
      ocolor_reg       <= sync_d.active ? pix_color : '0;
      ohsync_reg       <= sync_d.hsync;
      ovsync_reg       <= sync_d.vsync;
      oblank_reg       <= !sync_d.active;
      oframe_start_reg <= sync_d.frame_start;
    end
  end

  assign ocolor       = ocolor_reg;
  assign ohsync       = ohsync_reg;
  assign ovsync       = ovsync_reg;
  assign oblank       = oblank_reg;
  assign oframe_start = oframe_start_reg;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Scaled-down raster run of vga_frame_reader against a random-content RAM and an arithmetic raster model.
module tb_vga_frame_reader;

  localparam int HA = 24, HFP = 3, HS = 5, HBP = 4;
  localparam int VA = 12, VFP = 2, VS = 2, VBP = 3;
  localparam int LAT   = 2;
  localparam int HT    = HA + HFP + HS + HBP;
  localparam int VT    = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int NPIX  = HA * VA;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [18:0] oaddr;
  logic        ordreq;
  logic [7:0]  idata;
  logic [7:0]  ocolor;
  logic        ohsync, ovsync, oblank, oframe_start;

  always #5 clk = ~clk;

  vga_frame_reader #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
    .H_CNT_WIDTH (10), .V_CNT_WIDTH (10),
    .VGA_ADDR_WIDTH (19), .COLOR_ID_WIDTH (8),
    .RD_LATENCY (LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .oaddr        (oaddr),
    .ordreq       (ordreq),
    .idata        (idata),
    .ocolor       (ocolor),
    .ohsync       (ohsync),
    .ovsync       (ovsync),
    .oblank       (oblank),
    .oframe_start (oframe_start)
  );

  // RAM model: data appears LAT cycles after the address; garbage when not requested.
  logic [7:0] mem [NPIX];
  logic [7:0] rd_pipe [LAT];

  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= (ordreq && (oaddr < NPIX)) ? mem[oaddr] : 8'($urandom);
  end
  assign idata = rd_pipe[LAT-1];

  int checks = 0;
  int errors = 0;
  int c = 0;
  int fs_at[$];
  int req_cnt, hs_low, hs_first, vs_low, max_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  task automatic check_out_idle(input string ph);
    chk({ph, "_color"}, ocolor, 0);
    chk({ph, "_hsync"}, ohsync, 1);
    chk({ph, "_vsync"}, ovsync, 1);
    chk({ph, "_blank"}, oblank, 1);
    chk({ph, "_fstart"}, oframe_start, 0);
  endtask

  task automatic check_reset(input string ph);
    chk({ph, "_addr"}, oaddr, 0);
    chk({ph, "_rdreq"}, ordreq, 0);
    check_out_idle(ph);
  endtask

  task automatic clear_tally();
    fs_at.delete();
    req_cnt = 0; hs_low = 0; hs_first = -1; vs_low = 0; max_addr = 0;
  endtask

  // Cycle c counts edges since reset release; the counter stage shows pixel c-1, outputs show pixel c-2-LAT.
  task automatic check_cycle();
    int q0, q, x, y;
    logic act;
    q0 = c - 1;
    if (q0 < 0) begin
      chk("addr_idle", oaddr, 0);
      chk("rdreq_idle", ordreq, 0);
    end else begin
      x = q0 % HT;
      y = (q0 / HT) % VT;
      act = (x < HA) && (y < VA);
      chk("rdreq", ordreq, act);
      if (act) chk("addr", oaddr, y * HA + x);
    end
    chk("addr_range", oaddr < NPIX, 1);

    q = c - 2 - LAT;
    if (q < 0) begin
      check_out_idle("prefill");
    end else begin
      x = q % HT;
      y = (q / HT) % VT;
      act = (x < HA) && (y < VA);
      chk("color", ocolor, act ? mem[y * HA + x] : 8'h00);
      chk("blank", oblank, !act);
      chk("hsync", ohsync, !((x >= HA + HFP) && (x < HA + HFP + HS)));
      chk("vsync", ovsync, !((y >= VA + VFP) && (y < VA + VFP + VS)));
      chk("fstart", oframe_start, (x == 0) && (y == 0));
    end

    if (oframe_start) begin
      fs_at.push_back(c);
      $display("frame start at cycle %0d (checks so far %0d)", c, checks);
    end
    if (ordreq && c >= 1 && c <= FRAME) req_cnt++;
    if (!ohsync && c >= LAT + 2 && c <= LAT + 1 + HT) begin
      if (hs_low == 0) hs_first = c;
      hs_low++;
    end
    if (!ovsync && c >= LAT + 2 && c <= LAT + 1 + FRAME) vs_low++;
    if (int'(oaddr) > max_addr) max_addr = int'(oaddr);
  endtask

  task automatic tick();
    @(posedge clk);
    c++;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic check_tally(input string ph, input int n_fs);
    chk({ph, "_fs_count"}, fs_at.size(), n_fs);
    if (fs_at.size() >= 1) chk({ph, "_fs_first"}, fs_at[0], LAT + 2);
    if (fs_at.size() >= 2) chk({ph, "_fs_period"}, fs_at[1] - fs_at[0], FRAME);
    chk({ph, "_rdreq_per_frame"}, req_cnt, NPIX);
    chk({ph, "_hsync_width"}, hs_low, HS);
    chk({ph, "_hsync_offset"}, hs_first - (LAT + 2), HA + HFP);
    chk({ph, "_vsync_width"}, vs_low, VS * HT);
    chk({ph, "_addr_max"}, max_addr, NPIX - 1);
  endtask

  initial begin
    int mid;
    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < LAT; i++) rd_pipe[i] = 8'h00;

    // Power-on reset
    #1 rst = 1'b0;
    #1 check_reset("por_async");
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check_reset("por_hold");
    end
    $display("step: reset held, releasing");

    // Two full frames plus the start of a third
    rst = 1'b1;
    c = 0;
    clear_tally();
    check_cycle();
    repeat (2 * FRAME + LAT + 4) tick();
    check_tally("run1", 3);
    $display("step: two frames scanned, %0d checks, %0d errors", checks, errors);

    // Abort mid-frame with an asynchronous reset, then restart from (0,0)
    mid = 5 * HT + $urandom_range(1, HA - 2);
    repeat (mid) tick();
    #2 rst = 1'b0;
    #1 check_reset("mid_async");
    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check_reset("mid_hold");
    end
    $display("step: mid-frame reset after %0d extra cycles", mid);

    rst = 1'b1;
    c = 0;
    clear_tally();
    check_cycle();
    repeat (FRAME + LAT + 4) tick();
    check_tally("run2", 2);
    $display("step: frame after mid reset scanned");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- Scan-out side of the VGA frame buffer: generates 640x480@60 timing and reads color IDs from VGA RAM in raster order.
- Presents each color ID with hsync, vsync and blank aligned to it.
- Sits between the VGA RAM read port and the palette/DAC stage. The superpixel writer owns the RAM write port.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- H_CNT_WIDTH, 10, horizontal counter width (holds up to 799)
- V_CNT_WIDTH, 10, vertical counter width (holds up to 524)
- VGA_ADDR_WIDTH, 19, RAM address width
- COLOR_ID_WIDTH, 8, color index width
- RD_LATENCY, 2, RAM read latency in cycles (1..4)

Ports:
- clk  input  1  pixel clock (25 MHz nominal)
- rst  input  1  asynchronous, active-low reset
- oaddr  output  VGA_ADDR_WIDTH  RAM read address
- ordreq  output  1  RAM read enable; high only for active pixels
- idata  input  COLOR_ID_WIDTH  RAM read data; valid RD_LATENCY cycles after the address
- ocolor  output  COLOR_ID_WIDTH  color ID to palette; 0 while blanked
- ohsync  output  1  horizontal sync, active-low
- ovsync  output  1  vertical sync, active-low
- oblank  output  1  high outside the active area
- oframe_start  output  1  one-cycle pulse with the first active pixel (0,0) on ocolor

Behaviour:
- Counters
  - hcnt counts 0..799, then wraps to 0.
  - vcnt advances when hcnt wraps; it counts 0..524, then wraps to 0.
  - Active area: hcnt<640 && vcnt<480.
- Sync timing (counter stage)
  - hsync low for hcnt 656..751.
  - vsync low for vcnt 490..491.
- Address generation
  - Running address counter; no multiplier.
  - Increments by 1 on each active pixel.
  - Resets to 0 when hcnt==799 && vcnt==524.
  - oaddr = counter value; ordreq = active; both registered from the counter stage.
  - Invariant: at pixel (x,y), oaddr = y*640+x. Maximum 307199; the counter never exceeds it.
- Alignment pipeline
  - active, hsync, vsync and frame-start are each delayed by RD_LATENCY stages.
  - Output stage registers: ocolor = delayed_active ? idata : 0, plus all sync/blank outputs.
  - Total latency from the counter stage to the outputs is RD_LATENCY+1 cycles for every output, so all outputs stay mutually aligned.
- Reset (rst low, asynchronous)
  - Counters and pipeline clear.
  - oaddr=0, ordreq=0, ocolor=0, ohsync=1, ovsync=1, oblank=1, oframe_start=0.
  - After release: counting starts at (0,0); the first oframe_start appears RD_LATENCY+1 cycles later.
  - Reset asserted mid-frame aborts the frame immediately; no partial pipeline contents survive.
- No backpressure: the block free-runs.
- RAM write collisions are the writer's concern; read data is taken as-is.
- Wrap-around: hcnt 799→0 and vcnt 524→0 occur in the same cycle. The address counter reset takes priority over the increment. Not a conflict, since that position is inactive.

Optional Feature:
- Macro: SUPERPIXEL_GRID_EN.
- Defined:
  - Adds parameters GRID_PITCH=10 and GRID_COLOR=8'hFF.
  - Active pixels with x%GRID_PITCH==0 or y%GRID_PITCH==0 output GRID_COLOR instead of idata.
  - Modulo is implemented with wrapping sub-counters, not division.
  - The grid flag is delayed through the same pipeline as the other signals.
- Not defined: ocolor is always idata during the active area. No extra logic.

Decomposition:
- Shared package vga_pkg
  - Timing constants: totals 800/525, sync start/end values.
  - Widths: VGA_ADDR_WIDTH, COLOR_ID_WIDTH.
  - Typedef for the sync bundle {hsync, vsync, active, frame_start}.
- One sub-module, vga_timing_gen
  - Owns the h/v counters and raw sync/active flags.
  - Reused later by any overlay block.
- The address counter and alignment pipeline stay in vga_frame_reader.

Test Plan:
- Reset release → ohsync=ovsync=1, oblank=1 until cycle RD_LATENCY+1; oframe_start pulses exactly once there; RAM model returning addr[7:0] gives ocolor=0.
- Full frame with RAM model returning addr[7:0] → pixel (x,y) ocolor=(y*640+x)&8'hFF; 307200 ordreq cycles per frame; oaddr max 307199.
- Line timing → ohsync low for exactly 96 cycles, starting 656 cycles after the line's first active pixel at the output; 800 cycles per line.
- Frame timing → ovsync low for exactly 2 lines starting at line 490; 420000 cycles between oframe_start pulses.
- Assert rst mid-line 200 for 3 cycles → all outputs return to reset values immediately (asynchronous); restart from (0,0); next oframe_start occurs RD_LATENCY+1 cycles after release.
- RD_LATENCY=1 and 4 builds → ocolor, oblank and syncs stay mutually aligned; with SUPERPIXEL_GRID_EN, pixels (0,5), (10,7) and (3,20) show 8'hFF, while (5,5) shows the RAM data.
